// File: rtl/add_pkg.sv
// Shared types for the Sum_Difference adder datapath.
package add_pkg;

  localparam int ADD_WIDTH = 6;

  typedef logic [ADD_WIDTH-1:0] operand_t;

  typedef struct packed {
    operand_t sum;
    logic     of_s;
    logic     of_u;
  } add_result_t;

endpackage

// File: rtl/signed_adder_full_adder.sv
// One-bit full adder cell; the ripple chain in signed_adder is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/signed_adder.sv
// Registered two's-complement adder: ripple-carry sum plus signed/unsigned overflow flags.
module signed_adder
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic [WIDTH-1:0] sum,
  output logic             OF_S,
  output logic             OF_U
);

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             of_s_d, of_s_q;
  logic             of_u_d, of_u_q;

  // Per-bit carry nets keep the carry into the MSB visible for OF_S.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    logic ci, co;
    if (g == 0) begin : g_lsb
      assign ci = 1'b0;
    end else begin : g_mid
      assign ci = g_bit[g-1].co;
    end
    full_adder u_fa (
      .a    (inA[g]),
      .b    (inB[g]),
      .cin  (ci),
      .s    (sum_d[g]),
      .cout (co)
    );
  end

  assign of_u_d = g_bit[WIDTH-1].co;
  assign of_s_d = g_bit[WIDTH-1].co ^ g_bit[WIDTH-1].ci;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      of_s_q <= 1'b0;
      of_u_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      of_s_q <= of_s_d;
      of_u_q <= of_u_d;
    end
  end

  assign sum  = sum_q;
  assign OF_S = of_s_q;
  assign OF_U = of_u_q;

endmodule

// File: tb/tb_signed_adder.sv
// Directed + random checks of signed_adder against hand values and a small reference model.
module tb_signed_adder;
  import add_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] inA = '0;
  logic [5:0] inB = '0;
  logic [5:0] sum;
  logic       OF_S, OF_U;

  int tests = 0;
  int fails = 0;

  signed_adder #(.WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .inA   (inA),
    .inB   (inB),
    .sum   (sum),
    .OF_S  (OF_S),
    .OF_U  (OF_U)
  );

  always #5 clk = ~clk;

  function automatic add_result_t model(input operand_t a, input operand_t b);
    add_result_t r;
    logic [6:0]  full;
    full   = {1'b0, a} + {1'b0, b};
    r.sum  = full[5:0];
    r.of_u = full[6];
    r.of_s = (a[5] == b[5]) && (r.sum[5] != a[5]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [5:0] es, input logic eos, input logic eou);
    tests++;
    assert ({sum, OF_S, OF_U} === {es, eos, eou})
    else begin
      fails++;
      $error("FAIL %s: got sum=%0d OF_S=%b OF_U=%b, expected sum=%0d OF_S=%b OF_U=%b",
             tag, sum, OF_S, OF_U, es, eos, eou);
    end
  endtask

  // Drive on the falling edge, check just after the next rising edge.
  task automatic step(input logic [5:0] a, input logic [5:0] b);
    @(negedge clk);
    inA = a;
    inB = b;
    @(posedge clk);
    #1;
  endtask

  task automatic step_model(input string tag, input logic [5:0] a, input logic [5:0] b);
    add_result_t e;
    e = model(a, b);
    step(a, b);
    check(tag, e.sum, e.of_s, e.of_u);
  endtask

  initial begin
    logic [6:0]  wide;
    logic [5:0]  ra, rb;
    int          sweep_a[6] = '{15, 1, 14, 3, 6, 7};
    int          sweep_b[6] = '{8, 9, 10, 11, 14, 15};
    int          sweep_s[6] = '{23, 10, 24, 14, 20, 22};

    // Reset held with live operands
    inA = 6'd15;
    inB = 6'd8;
    #1;
    check("reset_t0", 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 6'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", 6'd23, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      step(6'(sweep_a[i]), 6'(sweep_b[i]));
      check("sweep", 6'(sweep_s[i]), 1'b0, 1'b0);
    end

    step(6'd32, 6'd32);
    check("neg_ovf", 6'd0, 1'b1, 1'b1);
    wide = 7'd64;
    step(wide[5:0], 6'd13);
    check("trunc64", 6'd13, 1'b0, 1'b0);

    step(6'd31, 6'd1);
    check("pos_ovf", 6'd32, 1'b1, 1'b0);
    step(6'd63, 6'd1);
    check("m1_p1", 6'd0, 1'b0, 1'b1);
    step(6'd40, 6'd20);
    check("opp_sign", 6'd60, 1'b0, 1'b0);

    // Back-to-back, new pair every cycle
    step(6'd15, 6'd8);
    check("b2b0", 6'd23, 1'b0, 1'b0);
    step(6'd31, 6'd9);
    check("b2b1", 6'd40, 1'b1, 1'b0);
    step_model("b2b2", 6'd32, 6'd10);
    step_model("b2b3", 6'd3, 6'd11);

    // Async reset mid-stream
    @(negedge clk);
    inA = 6'd20;
    inB = 6'd30;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_clr", 6'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("async_hold", 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("async_rel", 6'd50, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      step_model("random", ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/signed_adder.md
Name: signed_adder

Overview:
- Registered two's-complement adder for the Sum_Difference datapath.
- Adds two WIDTH-bit operands and reports the WIDTH-bit sum, a signed-overflow flag and an unsigned carry-out.
- Results are registered on the single system clock, with asynchronous active-low reset.
- Sits between operand-select logic and the display/compare stage.

Parameters:
- WIDTH, 6, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- inA  input  WIDTH  operand A, two's complement.
- inB  input  WIDTH  operand B, two's complement.
- sum  output  WIDTH  registered (inA + inB) mod 2^WIDTH.
- OF_S  output  1  registered signed-overflow flag.
- OF_U  output  1  registered unsigned carry-out of the MSB.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While rst_n=0:
  - sum=0, OF_S=0, OF_U=0 immediately, independent of clk.
  - Release is synchronous to the next rising edge: the first capture happens on the first rising edge with rst_n=1.
- Latency:
  - Inputs are sampled on the rising clk edge.
  - sum, OF_S and OF_U reflect those inputs from that edge until the next edge, so latency is 1 cycle.
  - No handshake; a new result every cycle.
- Arithmetic:
  - Full add of the WIDTH-bit inputs, carry-in 0.
  - sum = low WIDTH bits.
  - OF_U = carry out of bit WIDTH-1.
- Signed overflow: OF_S=1 iff inA[MSB]==inB[MSB] and sum[MSB]!=inA[MSB]. Equivalently, carry into the MSB XOR carry out of the MSB.
- Boundary cases:
  - Most-negative + most-negative (100000+100000) -> sum=000000, OF_S=1, OF_U=1.
  - Most-positive + 1 (011111+000001) -> sum=100000, OF_S=1, OF_U=0.
  - -1 + 1 -> sum=0, OF_S=0, OF_U=1.
  - Opposite-sign operands never set OF_S.
- Reset mid-operation: outputs clear asynchronously. A pending input is not captured until the first rising edge after release.
- X/Z on inputs are not handled specially. The bench drives known values before releasing reset.
- Structure: ripple-carry chain of WIDTH one-bit full adders feeding the output register. No library "+" operator in the carry path, so the carry-into-MSB is explicitly available for OF_S.

Decomposition:
- Shared package add_pkg:
  - default width constant ADD_WIDTH=6.
  - typedef operand_t as logic [ADD_WIDTH-1:0].
  - typedef add_result_t as a struct {operand_t sum; logic of_s; logic of_u}.
- One sub-module, full_adder:
  - inputs a, b, cin; outputs s, cout; purely combinational.
  - Instantiated WIDTH times by a generate loop in signed_adder.
- Output register and flag logic live in signed_adder itself.

Test Plan:
- Reset: hold rst_n=0 with inA=15, inB=8 for 3 edges -> sum=0, OF_S=0, OF_U=0 throughout. Release; after the next edge -> sum=23, OF_S=0, OF_U=0.
- Non-overflow sweep: one pair per cycle, each checked one edge after drive; all OF_S=0, OF_U=0.
  - (15,8)->23
  - (1,9)->10
  - (14,10)->24
  - (3,11)->14
  - (6,14)->20
  - (7,15)->22
- Negative overflow: inA=32 (-32), inB=32 (-32) -> sum=0, OF_S=1, OF_U=1. A truncated 7-bit value 64 on inA (reads as 0) with inB=13 -> sum=13, OF_S=0.
- Positive overflow: (31,1) -> sum=32 (-32), OF_S=1, OF_U=0. (-1=63, 1) -> sum=0, OF_S=0, OF_U=1.
- Latency and back-to-back: change inputs every cycle (A: 15,31,32,3). Outputs follow exactly one edge later, no bubbles: sum 23,40(-24),... against a reference model. Assert rst_n low mid-stream -> outputs clear asynchronously before the next edge.
- Random: 1000 random pairs -> sum, OF_S, OF_U match the model, with OF_S computed from sign bits.
